// File: rtl/apb_fifo_periph.sv
// rtl/apb_fifo_periph.sv - APB completer hosting a memory-mapped 32-bit data FIFO
module apb_fifo_periph #(
  parameter int DEPTH = 8
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic [3:0]  PADDR,
  input  logic [31:0] PWDATA,
  input  logic        PWRITE,
  input  logic        PENABLE,
  input  logic        PSEL,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        irq
);

  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [0:0] STATE_IDLE = 1'b0;
  localparam logic [0:0] STATE_RESP = 1'b1;

  localparam logic [1:0] ADDR_FCR = 2'd0;
  localparam logic [1:0] ADDR_FSR = 2'd1;
  localparam logic [1:0] ADDR_FWD = 2'd2;
  localparam logic [1:0] ADDR_FRD = 2'd3;

  localparam logic [PTR_W:0] COUNT_FULL = (PTR_W + 1)'(DEPTH);

  logic [31:0]      mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [PTR_W:0]   count;
  logic [0:0]       state;
  logic             ie;
  logic             ovf;
  logic             unf;

  logic [1:0]       word_addr;
  logic             access;
  logic             empty;
  logic             full;
  logic             do_push;
  logic             do_pop;
  logic             do_clr;
  logic [31:0]      fsr_word;
  logic [31:0]      rdata_next;
  logic             unused_paddr;

  assign word_addr    = PADDR[3:2];
  assign unused_paddr = ^PADDR[1:0];

  // Side effects fire only from IDLE, so a long-held PSEL still gives one push/pop.
  assign access  = (state == STATE_IDLE) && PSEL && PENABLE;
  assign empty   = (count == '0);
  assign full    = (count == COUNT_FULL);
  assign do_push = access && PWRITE && (word_addr == ADDR_FWD) && !full;
  assign do_pop  = access && !PWRITE && (word_addr == ADDR_FRD) && !empty;
  assign do_clr  = access && PWRITE && (word_addr == ADDR_FCR) && PWDATA[0];

  assign irq = ie && !empty;

  always_comb begin
    fsr_word              = '0;
    fsr_word[0]           = empty;
    fsr_word[1]           = full;
    fsr_word[2]           = ovf;
    fsr_word[3]           = unf;
    fsr_word[PTR_W+4:4]   = count;
  end

  always_comb begin
    rdata_next = '0;
    case (word_addr)
      ADDR_FCR: rdata_next = {30'b0, ie, 1'b0};
      ADDR_FSR: rdata_next = fsr_word;
      ADDR_FWD: rdata_next = '0;
      ADDR_FRD: rdata_next = empty ? 32'b0 : mem[rptr];
      default:  rdata_next = '0;
    endcase
  end

  // Storage has no reset; its contents are only meaningful below count.
  always_ff @(posedge PCLK) begin
    if (do_push) begin
      mem[wptr] <= PWDATA;
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state  <= STATE_IDLE;
      PREADY <= 1'b0;
      PRDATA <= '0;
      ie     <= 1'b0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
    end else begin
      case (state)
        STATE_IDLE: begin
          if (PSEL && PENABLE) begin
            state  <= STATE_RESP;
            PREADY <= 1'b1;
            PRDATA <= PWRITE ? 32'b0 : rdata_next;
            if (PWRITE) begin
              case (word_addr)
                ADDR_FCR: ie <= PWDATA[1];
                ADDR_FSR: begin
                  ovf <= ovf & ~PWDATA[2];
                  unf <= unf & ~PWDATA[3];
                end
                ADDR_FWD: begin
                  if (full) begin
                    ovf <= 1'b1;
                  end
                end
                default: ;
              endcase
            end else if ((word_addr == ADDR_FRD) && empty) begin
              unf <= 1'b1;
            end
          end else begin
            PREADY <= 1'b0;
          end
        end
        STATE_RESP: begin
          state  <= STATE_IDLE;
          PREADY <= 1'b0;
        end
        default: begin
          state  <= STATE_IDLE;
          PREADY <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (do_clr) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        wptr  <= wptr + 1'b1;
        count <= count + 1'b1;
      end
      if (do_pop) begin
        rptr  <= rptr + 1'b1;
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_fifo_periph.sv
// tb/tb_apb_fifo_periph.sv - scoreboard bench for apb_fifo_periph
module tb_apb_fifo_periph;

  localparam logic [3:0] A_FCR = 4'h0;
  localparam logic [3:0] A_FSR = 4'h4;
  localparam logic [3:0] A_FWD = 4'h8;
  localparam logic [3:0] A_FRD = 4'hC;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic [3:0]  PADDR = '0;
  logic [31:0] PWDATA = '0;
  logic        PWRITE = 1'b0;
  logic        PENABLE = 1'b0;
  logic        PSEL = 1'b0;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        irq;

  int tests = 0;
  int fails = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  apb_fifo_periph #(.DEPTH(8)) dut (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PWRITE  (PWRITE),
    .PENABLE (PENABLE),
    .PSEL    (PSEL),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .irq     (irq)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One APB transfer: setup, access until PREADY (bounded), then idle.
  task automatic xfer(input logic wr, input logic [3:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rdata);
    int waited;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    chk("pready_first_access", {31'b0, PREADY}, 32'd0);
    waited = 0;
    do begin
      @(posedge PCLK); #1;
      waited++;
    end while (PREADY !== 1'b1 && waited < 4);
    chk("wait_states", waited, 32'd1);
    rdata = PRDATA;
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    chk("pready_one_cycle", {31'b0, PREADY}, 32'd0);
  endtask

  task automatic rd(input logic [3:0] addr, input logic [31:0] exp, input string tag);
    logic [31:0] r;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    xfer(1'b0, addr, 32'b0, r);
    chk(tag_q.pop_front(), r, exp_q.pop_front());
  endtask

  task automatic wr(input logic [3:0] addr, input logic [31:0] data);
    logic [31:0] r;
    exp_q.push_back(32'b0);
    tag_q.push_back("write_prdata");
    xfer(1'b1, addr, data, r);
    chk(tag_q.pop_front(), r, exp_q.pop_front());
  endtask

  initial begin
    repeat (3) @(posedge PCLK);
    #1;
    chk("reset_pready", {31'b0, PREADY}, 32'd0);
    chk("reset_prdata", PRDATA, 32'd0);
    chk("reset_irq", {31'b0, irq}, 32'd0);
    PRESET = 1'b0;
    @(posedge PCLK); #1;

    rd(A_FSR, 32'h1, "fsr_after_reset");

    wr(A_FWD, 32'h11); wr(A_FWD, 32'h22); wr(A_FWD, 32'h33);
    rd(A_FSR, 32'h30, "fsr_count3");
    rd(A_FRD, 32'h11, "pop_11");
    rd(A_FRD, 32'h22, "pop_22");
    rd(A_FRD, 32'h33, "pop_33");
    rd(A_FSR, 32'h1, "fsr_drained");

    for (int i = 1; i <= 9; i++) wr(A_FWD, i);
    rd(A_FSR, 32'h86, "fsr_full_ovf");
    for (int i = 1; i <= 8; i++) rd(A_FRD, i, "pop_overflow_seq");
    rd(A_FSR, 32'h5, "fsr_empty_ovf");
    wr(A_FSR, 32'h4);
    rd(A_FSR, 32'h1, "fsr_ovf_cleared");

    rd(A_FRD, 32'h0, "pop_empty");
    rd(A_FSR, 32'h9, "fsr_unf");
    wr(A_FSR, 32'h8);
    rd(A_FSR, 32'h1, "fsr_unf_cleared");
    rd(A_FWD, 32'h0, "fwd_read_zero");
    rd(A_FCR, 32'h0, "fcr_reset");

    for (int i = 0; i < 6; i++) wr(A_FWD, 32'h60 + i);
    for (int i = 0; i < 6; i++) rd(A_FRD, 32'h60 + i, "pop_pre_wrap");
    for (int i = 0; i < 8; i++) wr(A_FWD, 32'hA0 + i);
    rd(A_FSR, 32'h82, "fsr_wrap_full");
    wr(A_FRD, 32'hDEAD);
    rd(A_FSR, 32'h82, "frd_write_ignored");
    for (int i = 0; i < 8; i++) rd(A_FRD, 32'hA0 + i, "pop_wrap");
    rd(A_FSR, 32'h1, "fsr_wrap_empty");

    wr(A_FCR, 32'h2);
    chk("irq_ie_empty", {31'b0, irq}, 32'd0);
    wr(A_FWD, 32'h5);
    chk("irq_after_push", {31'b0, irq}, 32'd1);
    rd(A_FCR, 32'h2, "fcr_ie");
    wr(A_FCR, 32'h3);
    chk("irq_after_clear", {31'b0, irq}, 32'd0);
    rd(A_FSR, 32'h1, "fsr_after_clear");
    rd(A_FCR, 32'h2, "fcr_clr_selfclear");

    // Reset while the push transfer sits in its PREADY cycle.
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = A_FWD; PWDATA = 32'h77;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    chk("pready_before_reset", {31'b0, PREADY}, 32'd1);
    PRESET = 1'b1;
    #1;
    chk("pready_async_reset", {31'b0, PREADY}, 32'd0);
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    @(posedge PCLK); #1;
    chk("irq_after_reset", {31'b0, irq}, 32'd0);
    rd(A_FSR, 32'h1, "fsr_after_midreset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
